// File: rtl/jvm_pkg.sv
// Shared opcode constants, FSM/ALU enums and decode helpers for the JVM execute stage.
package jvm_pkg;

  localparam logic [7:0] OP_NOP       = 8'h00;
  localparam logic [7:0] OP_ICONST_M1 = 8'h02;
  localparam logic [7:0] OP_ICONST_0  = 8'h03;
  localparam logic [7:0] OP_ICONST_1  = 8'h04;
  localparam logic [7:0] OP_ICONST_2  = 8'h05;
  localparam logic [7:0] OP_ICONST_3  = 8'h06;
  localparam logic [7:0] OP_ICONST_4  = 8'h07;
  localparam logic [7:0] OP_ICONST_5  = 8'h08;
  localparam logic [7:0] OP_BIPUSH    = 8'h10;
  localparam logic [7:0] OP_SIPUSH    = 8'h11;
  localparam logic [7:0] OP_POP       = 8'h57;
  localparam logic [7:0] OP_DUP       = 8'h59;
  localparam logic [7:0] OP_IADD      = 8'h60;
  localparam logic [7:0] OP_ISUB      = 8'h64;
  localparam logic [7:0] OP_IAND      = 8'h7E;
  localparam logic [7:0] OP_IOR       = 8'h80;
  localparam logic [7:0] OP_IXOR      = 8'h82;

  typedef enum logic [2:0] {
    IDLE, POP1, WAIT1, POP2, WAIT2, PUSH, WAITP, DONE
  } ctrl_state_t;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR
  } alu_op_t;

  // Which stack-transaction sequence an opcode needs.
  typedef enum logic [2:0] {
    CLS_NONE, CLS_PUSH, CLS_POP, CLS_DUP, CLS_BIN
  } op_class_t;

  function automatic op_class_t op_class(input logic [7:0] op);
    op_class_t cls;
    cls = CLS_NONE;
    case (op)
      OP_ICONST_M1, OP_ICONST_0, OP_ICONST_1, OP_ICONST_2,
      OP_ICONST_3, OP_ICONST_4, OP_ICONST_5,
      OP_BIPUSH, OP_SIPUSH:                       cls = CLS_PUSH;
      OP_POP:                                     cls = CLS_POP;
      OP_DUP:                                     cls = CLS_DUP;
      OP_IADD, OP_ISUB, OP_IAND, OP_IOR, OP_IXOR: cls = CLS_BIN;
      default:                                    cls = CLS_NONE;
    endcase
    return cls;
  endfunction

  function automatic alu_op_t alu_sel(input logic [7:0] op);
    alu_op_t sel;
    sel = ALU_ADD;
    case (op)
      OP_ISUB: sel = ALU_SUB;
      OP_IAND: sel = ALU_AND;
      OP_IOR:  sel = ALU_OR;
      OP_IXOR: sel = ALU_XOR;
      default: sel = ALU_ADD;
    endcase
    return sel;
  endfunction

  // Instruction length in bytes, i.e. how far the fetch unit advances the PC.
  function automatic logic [1:0] op_len(input logic [7:0] op);
    logic [1:0] len;
    len = 2'd1;
    case (op)
      OP_BIPUSH: len = 2'd2;
      OP_SIPUSH: len = 2'd3;
      default:   len = 2'd1;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/jvm_alu.sv
// Combinational integer ALU for the binary JVM ops; results wrap in two's complement.
module jvm_alu
  import jvm_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  alu_op_t           alu_op,
  output logic [DATA_W-1:0] result
);

  always_comb begin
    result = '0;
    case (alu_op)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/jvm_control.sv
// Execute-stage controller: decodes one opcode, sequences pops/pushes on the
// external operand stack through the stack32 handshake and reports op_done/offset.
module jvm_control
  import jvm_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int OFFSET_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [7:0]          op_code,
  input  logic [7:0]          arg1,
  input  logic [7:0]          arg2,
  input  logic [DATA_W-1:0]   stackread,
  input  logic                stackdone,
  output logic [DATA_W-1:0]   stackwrite,
  output logic                stackpush,
  output logic                stacktrigger,
  output logic [OFFSET_W-1:0] offset,
  output logic                op_done
);

  ctrl_state_t       state, next_state;
  op_class_t         cls_reg;
  alu_op_t           alu_reg;
  logic [1:0]        len_reg;
  logic [1:0]        len_next;
  logic [DATA_W-1:0] b_reg;
  logic              dup_again;
  logic [7:0]        iconst_byte;
  logic [DATA_W-1:0] push_const;
  logic [DATA_W-1:0] alu_result;
  logic              trigger_next;

  // iconst_m1..iconst_5 are encoded as value + 3.
  assign iconst_byte = op_code - 8'd3;

  always_comb begin
    push_const = {{(DATA_W-8){iconst_byte[7]}}, iconst_byte};
    case (op_code)
      OP_BIPUSH: push_const = {{(DATA_W-8){arg1[7]}}, arg1};
      OP_SIPUSH: push_const = {{(DATA_W-16){arg1[7]}}, arg1, arg2};
      default:   push_const = {{(DATA_W-8){iconst_byte[7]}}, iconst_byte};
    endcase
  end

  // In WAIT2 stackread carries operand a (second pop); b is the former top of stack.
  jvm_alu #(.DATA_W(DATA_W)) u_alu (
    .a      (stackread),
    .b      (b_reg),
    .alu_op (alu_reg),
    .result (alu_result)
  );

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        case (op_class(op_code))
          CLS_PUSH:                  next_state = PUSH;
          CLS_POP, CLS_DUP, CLS_BIN: next_state = POP1;
          default:                   next_state = DONE;
        endcase
      end
      POP1:  next_state = WAIT1;
      WAIT1: begin
        if (stackdone) begin
          if (cls_reg == CLS_BIN)      next_state = POP2;
          else if (cls_reg == CLS_DUP) next_state = PUSH;
          else                         next_state = DONE;
        end
      end
      POP2:  next_state = WAIT2;
      WAIT2: if (stackdone) next_state = PUSH;
      PUSH:  next_state = WAITP;
      WAITP: begin
        if (stackdone) begin
          if (cls_reg == CLS_DUP && !dup_again) next_state = PUSH;
          else                                  next_state = DONE;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign trigger_next = (next_state == POP1) || (next_state == POP2) || (next_state == PUSH);
  assign len_next     = (state == IDLE) ? op_len(op_code) : len_reg;

  // Handshake outputs are registered off next_state so they are glitch-free in the trigger cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cls_reg      <= CLS_NONE;
      alu_reg      <= ALU_ADD;
      len_reg      <= 2'd1;
      b_reg        <= '0;
      dup_again    <= 1'b0;
      stackwrite   <= '0;
      stackpush    <= 1'b0;
      stacktrigger <= 1'b0;
      offset       <= '0;
      op_done      <= 1'b0;
    end else begin
      state        <= next_state;
      stacktrigger <= trigger_next;
      op_done      <= (next_state == DONE);
      if (trigger_next)
        stackpush <= (next_state == PUSH);
      if (next_state == DONE)
        offset <= OFFSET_W'(len_next);
      if (state == IDLE) begin
        cls_reg   <= op_class(op_code);
        alu_reg   <= alu_sel(op_code);
        len_reg   <= op_len(op_code);
        dup_again <= 1'b0;
        if (next_state == PUSH)
          stackwrite <= push_const;
      end
      if (state == WAIT1 && stackdone) begin
        b_reg <= stackread;
        if (cls_reg == CLS_DUP)
          stackwrite <= stackread;
      end
      if (state == WAIT2 && stackdone)
        stackwrite <= alu_result;
      if (state == WAITP && next_state == PUSH)
        dup_again <= 1'b1;
    end
  end

endmodule

// File: tb/tb_jvm_control.sv
// Scoreboard bench for jvm_control: a behavioural stack answers the handshake and
// a JVM model queues the expected pushes, offsets and latencies.
module tb_jvm_control;
  import jvm_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  op_code = OP_NOP;
  logic [7:0]  arg1 = '0;
  logic [7:0]  arg2 = '0;
  logic [31:0] stackread = '0;
  logic        stackdone = 1'b0;
  logic [31:0] stackwrite;
  logic        stackpush;
  logic        stacktrigger;
  logic [15:0] offset;
  logic        op_done;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem[$];
  logic [31:0] model[$];
  logic [31:0] exp_push[$];

  int          stack_delay = 1;
  bit          after_done = 0;
  bit          busy = 0;
  int          busy_cnt = 0;
  logic [31:0] pend = '0;

  jvm_control #(.DATA_W(32), .OFFSET_W(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .op_code      (op_code),
    .arg1         (arg1),
    .arg2         (arg2),
    .stackread    (stackread),
    .stackdone    (stackdone),
    .stackwrite   (stackwrite),
    .stackpush    (stackpush),
    .stacktrigger (stacktrigger),
    .offset       (offset),
    .op_done      (op_done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Behavioural stack: answers each trigger with a stackdone pulse stack_delay cycles later.
  always @(negedge clk) begin
    if (!rst_n) begin
      busy      = 0;
      stackdone = 1'b0;
    end else begin
      stackdone = 1'b0;
      if (busy) begin
        checkOutput("single_outstanding", {31'b0, stacktrigger}, 32'd0);
        checkOutput("done_held_low", {31'b0, op_done}, 32'd0);
        busy_cnt--;
        if (busy_cnt == 0) begin
          stackdone = 1'b1;
          stackread = pend;
          busy      = 0;
        end
      end else if (stacktrigger) begin
        if (stackpush) begin
          checkOutput("push_expected", {31'b0, exp_push.size() != 0}, 32'd1);
          if (exp_push.size() != 0)
            checkOutput("push_value", stackwrite, exp_push.pop_front());
          mem.push_back(stackwrite);
          pend = '0;
        end else begin
          checkOutput("pop_avail", {31'b0, mem.size() != 0}, 32'd1);
          pend = (mem.size() != 0) ? mem.pop_back() : 32'hDEAD_BEEF;
        end
        busy     = 1;
        busy_cnt = stack_delay;
      end
    end
  end

  task automatic preload(input logic [31:0] v);
    mem.push_back(v);
    model.push_back(v);
  endtask

  task automatic applyStimulus(input logic [7:0] op, input logic [7:0] a1, input logic [7:0] a2);
    logic [31:0] a, b, v;
    int          ntrans, exp_lat, cycles;
    logic [15:0] exp_off;
    exp_off = 16'd1;
    ntrans  = 0;
    if (op >= OP_ICONST_M1 && op <= OP_ICONST_5) begin
      v = int'(op) - 3;
      exp_push.push_back(v); model.push_back(v); ntrans = 1;
    end else if (op == OP_BIPUSH) begin
      v = 32'($signed(a1));
      exp_push.push_back(v); model.push_back(v); ntrans = 1; exp_off = 16'd2;
    end else if (op == OP_SIPUSH) begin
      v = 32'($signed({a1, a2}));
      exp_push.push_back(v); model.push_back(v); ntrans = 1; exp_off = 16'd3;
    end else if (op == OP_IADD || op == OP_ISUB || op == OP_IAND || op == OP_IOR || op == OP_IXOR) begin
      b = model.pop_back();
      a = model.pop_back();
      case (op)
        OP_IADD: v = a + b;
        OP_ISUB: v = a - b;
        OP_IAND: v = a & b;
        OP_IOR:  v = a | b;
        default: v = a ^ b;
      endcase
      exp_push.push_back(v); model.push_back(v); ntrans = 3;
    end else if (op == OP_DUP) begin
      v = model[$];
      exp_push.push_back(v); exp_push.push_back(v); model.push_back(v); ntrans = 3;
    end else if (op == OP_POP) begin
      v = model.pop_back(); ntrans = 1;
    end
    exp_lat = 1 + ntrans * (1 + stack_delay);

    op_code = op;
    arg1    = a1;
    arg2    = a2;
    if (after_done) @(negedge clk);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!op_done && cycles < 200);
    checkOutput($sformatf("op%02h_done", op), {31'b0, op_done}, 32'd1);
    checkOutput($sformatf("op%02h_latency", op), cycles, exp_lat);
    checkOutput($sformatf("op%02h_offset", op), {16'b0, offset}, {16'b0, exp_off});
    after_done = 1;
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_stackwrite"}, stackwrite, 32'd0);
    checkOutput({tag, "_stackpush"}, {31'b0, stackpush}, 32'd0);
    checkOutput({tag, "_stacktrigger"}, {31'b0, stacktrigger}, 32'd0);
    checkOutput({tag, "_offset"}, {16'b0, offset}, 32'd0);
    checkOutput({tag, "_op_done"}, {31'b0, op_done}, 32'd0);
    checkOutput({tag, "_state"}, 32'(dut.state), 32'(IDLE));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    #12;
    checkIdleOutputs("reset");
    @(negedge clk);
    rst_n      = 1'b1;
    after_done = 0;

    $display("[TB] constants and binary arithmetic");
    applyStimulus(OP_ICONST_M1, 8'h00, 8'h00);
    applyStimulus(OP_ICONST_2,  8'h00, 8'h00);
    applyStimulus(OP_ICONST_2,  8'h00, 8'h00);
    applyStimulus(OP_IADD,      8'h00, 8'h00);
    applyStimulus(OP_IADD,      8'h00, 8'h00);
    applyStimulus(OP_BIPUSH,    8'h80, 8'h00);
    applyStimulus(OP_SIPUSH,    8'h12, 8'h34);
    applyStimulus(OP_ICONST_5,  8'h00, 8'h00);
    applyStimulus(OP_BIPUSH,    8'h07, 8'h00);
    applyStimulus(OP_ISUB,      8'h00, 8'h00);
    preload(32'h7FFF_FFFF);
    preload(32'h0000_0001);
    applyStimulus(OP_IADD,      8'h00, 8'h00);
    preload(32'hF0F0_F0F0);
    preload(32'h3C3C_3C3C);
    applyStimulus(OP_IAND,      8'h00, 8'h00);
    preload(32'h00FF_0000);
    applyStimulus(OP_IOR,       8'h00, 8'h00);
    applyStimulus(OP_ICONST_M1, 8'h00, 8'h00);
    applyStimulus(OP_IXOR,      8'h00, 8'h00);
    applyStimulus(OP_DUP,       8'h00, 8'h00);
    applyStimulus(OP_POP,       8'h00, 8'h00);
    applyStimulus(OP_NOP,       8'h00, 8'h00);
    applyStimulus(8'hFF,        8'h00, 8'h00);
    applyStimulus(OP_SIPUSH,    8'hFF, 8'h00);

    $display("[TB] slow stack responses");
    stack_delay = 3;
    applyStimulus(OP_ICONST_3,  8'h00, 8'h00);
    applyStimulus(OP_ICONST_4,  8'h00, 8'h00);
    applyStimulus(OP_IADD,      8'h00, 8'h00);
    applyStimulus(OP_DUP,       8'h00, 8'h00);
    applyStimulus(OP_POP,       8'h00, 8'h00);
    stack_delay = 1;

    $display("[TB] reset during iadd");
    preload(32'h0000_0011);
    preload(32'h0000_0022);
    op_code = OP_IADD;
    @(negedge clk);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 checkIdleOutputs("abort");
    mem.delete();
    model.delete();
    op_code = OP_NOP;
    repeat (2) @(negedge clk);
    rst_n      = 1'b1;
    after_done = 0;
    applyStimulus(OP_NOP, 8'h00, 8'h00);

    checkOutput("scoreboard_empty", exp_push.size(), 32'd0);
    checkOutput("stack_depth", mem.size(), model.size());
    for (int i = 0; i < mem.size() && i < model.size(); i++)
      checkOutput($sformatf("stack_entry%0d", i), mem[i], model[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
